// File: rtl/svga_pixel_pipeline_if.sv
// Memory-side bus of the SVGA pixel pipeline: video RAM and font ROM ports.
// Both memories are synchronous, with data valid one cycle after the address.
interface svga_pixel_pipeline_if;
  logic [10:0] vram_addr;
  logic [7:0]  vram_data;
  logic [9:0]  font_addr;
  logic [7:0]  font_data;

  modport master (
    output vram_addr,
    output font_addr,
    input  vram_data,
    input  font_data
  );

  modport slave (
    input  vram_addr,
    input  font_addr,
    output vram_data,
    output font_data
  );
endinterface

// File: rtl/svga_pixel_pipeline.sv
// Seven-stage text/graphics pixel pipeline: counters in, video RAM and font ROM
// fetch, pixel select, palette lookup and registered rgb out.
module svga_pixel_pipeline (
  input  logic                         pixel_clock,
  input  logic                         reset,
  svga_pixel_pipeline_if.master        mem,
  input  logic                         blank,
  input  logic                         show_border,
  input  logic [3:0]                   subchar_pixel,
  input  logic [4:0]                   subchar_line,
  input  logic [6:0]                   char_column,
  input  logic [6:0]                   char_line,
  input  logic [8:0]                   graph_pixel,
  input  logic [9:0]                   graph_line_3x,
  input  logic                         mode_graph,
  input  logic                         css,
  output logic [23:0]                  rgb
);

  localparam logic [23:0] ColBlack  = 24'h000000;
  localparam logic [23:0] ColTextBg = 24'h003000;
  localparam logic [23:0] ColGreen  = 24'h00FF00;
  localparam logic [23:0] ColOrange = 24'hFF8000;
  localparam logic [23:0] ColBuff   = 24'hFFFFC0;

  // Per-pixel control carried alongside the fetch so mode/css follow each pixel.
  typedef struct packed {
    logic       valid;
    logic       mode;
    logic       css;
    logic [3:0] row;
    logic [2:0] bit_idx;
    logic [1:0] pair;
  } ctl_t;

  typedef enum logic [1:0] {
    PixBlack,
    PixTextBg,
    PixTextFg,
    PixPalette
  } pix_cls_e;

  ctl_t        ctl1_d, ctl1_q, ctl2_q, ctl3_q, ctl4_q, ctl5_q;
  logic [10:0] vram_addr_d, vram_addr_q;
  logic [9:0]  font_addr_q;
  logic [7:0]  code3_q, code4_q, code5_q;

  pix_cls_e    cls6_d, cls6_q;
  logic [2:0]  idx6_d, idx6_q;
  logic        valid6_q, mode6_q, css6_q;

  logic [1:0]  gfx_c;
  logic [1:0]  quad;
  logic [23:0] pipe_rgb, border_rgb, rgb_d, rgb_q;

  logic unused_bits;
  assign unused_bits = ^{char_column[6:5], char_line[6:4], subchar_line[0], subchar_pixel[0],
                         graph_pixel[1:0], graph_line_3x[9], graph_line_3x[2:0]};

  function automatic logic [23:0] palette8(input logic [2:0] idx);
    logic [23:0] c;
    c = ColBlack;
    unique case (idx)
      3'd0: c = ColGreen;
      3'd1: c = 24'hFFFF00;
      3'd2: c = 24'h0000FF;
      3'd3: c = 24'hFF0000;
      3'd4: c = ColBuff;
      3'd5: c = 24'h00FFFF;
      3'd6: c = 24'hFF00FF;
      3'd7: c = ColOrange;
    endcase
    return c;
  endfunction

  // S1: address and selector capture.
  always_comb begin
    ctl1_d         = '0;
    ctl1_d.valid   = 1'b1;
    ctl1_d.mode    = mode_graph;
    ctl1_d.css     = css;
    ctl1_d.row     = subchar_line[4:1];
    ctl1_d.bit_idx = ~subchar_pixel[3:1];
    ctl1_d.pair    = graph_pixel[3:2];
    if (mode_graph) begin
      vram_addr_d = {graph_line_3x[8:3], graph_pixel[8:4]};
    end else begin
      vram_addr_d = {2'b00, char_line[3:0], char_column[4:0]};
    end
  end

  // S6: reduce the fetched byte to a colour class plus palette index.
  always_comb begin
    cls6_d = PixBlack;
    idx6_d = '0;
    gfx_c  = '0;
    quad   = '0;
    if (ctl5_q.mode) begin
      unique case (ctl5_q.pair)
        2'd0: gfx_c = code5_q[7:6];
        2'd1: gfx_c = code5_q[5:4];
        2'd2: gfx_c = code5_q[3:2];
        2'd3: gfx_c = code5_q[1:0];
      endcase
      cls6_d = PixPalette;
      idx6_d = {ctl5_q.css, gfx_c};
    end else if (code5_q[7]) begin
      // Quadrant bit 3 is top-left, so top and left both raise the index.
      quad   = {ctl5_q.row < 4'd6, ctl5_q.bit_idx >= 3'd4};
      idx6_d = code5_q[6:4];
      cls6_d = code5_q[quad] ? PixPalette : PixBlack;
    end else begin
      cls6_d = (mem.font_data[ctl5_q.bit_idx] ^ code5_q[6]) ? PixTextFg : PixTextBg;
    end
  end

  // S7: palette lookup, then blank and border override.
  always_comb begin
    pipe_rgb = ColBlack;
    unique case (cls6_q)
      PixBlack:   pipe_rgb = ColBlack;
      PixTextBg:  pipe_rgb = ColTextBg;
      PixTextFg:  pipe_rgb = css6_q ? ColOrange : ColGreen;
      PixPalette: pipe_rgb = palette8(idx6_q);
    endcase
    border_rgb = mode6_q ? (css6_q ? ColBuff : ColGreen) : ColBlack;
    if (blank || !valid6_q) begin
      rgb_d = ColBlack;
    end else if (show_border) begin
      rgb_d = border_rgb;
    end else begin
      rgb_d = pipe_rgb;
    end
  end

  always_ff @(posedge pixel_clock or negedge reset) begin
    if (!reset) begin
      vram_addr_q <= '0;
      font_addr_q <= '0;
      ctl1_q      <= '0;
      ctl2_q      <= '0;
      ctl3_q      <= '0;
      ctl4_q      <= '0;
      ctl5_q      <= '0;
      code3_q     <= '0;
      code4_q     <= '0;
      code5_q     <= '0;
      cls6_q      <= PixBlack;
      idx6_q      <= '0;
      valid6_q    <= 1'b0;
      mode6_q     <= 1'b0;
      css6_q      <= 1'b0;
      rgb_q       <= '0;
    end else begin
      vram_addr_q <= vram_addr_d;
      ctl1_q      <= ctl1_d;
      ctl2_q      <= ctl1_q;
      ctl3_q      <= ctl2_q;
      code3_q     <= mem.vram_data;
      ctl4_q      <= ctl3_q;
      code4_q     <= code3_q;
      // Graphics pixels leave the font address alone.
      if (!ctl3_q.mode) begin
        font_addr_q <= {code3_q[5:0], ctl3_q.row};
      end
      ctl5_q      <= ctl4_q;
      code5_q     <= code4_q;
      cls6_q      <= cls6_d;
      idx6_q      <= idx6_d;
      valid6_q    <= ctl5_q.valid;
      mode6_q     <= ctl5_q.mode;
      css6_q      <= ctl5_q.css;
      rgb_q       <= rgb_d;
    end
  end

  assign mem.vram_addr = vram_addr_q;
  assign mem.font_addr = font_addr_q;
  assign rgb           = rgb_q;

endmodule

// File: tb/tb_svga_pixel_pipeline.sv
// Bench for svga_pixel_pipeline: directed vector table, hand sequences for mode
// switch / blank / border / reset, and random stimulus against a colour model.
module tb_svga_pixel_pipeline;

  logic        pixel_clock = 1'b0;
  logic        reset = 1'b1;
  logic        blank, show_border, mode_graph, css;
  logic [3:0]  subchar_pixel;
  logic [4:0]  subchar_line;
  logic [6:0]  char_column, char_line;
  logic [8:0]  graph_pixel;
  logic [9:0]  graph_line_3x;
  logic [23:0] rgb;

  int tests = 0;
  int failed = 0;

  svga_pixel_pipeline_if mem_if ();

  svga_pixel_pipeline dut (
    .pixel_clock   (pixel_clock),
    .reset         (reset),
    .mem           (mem_if),
    .blank         (blank),
    .show_border   (show_border),
    .subchar_pixel (subchar_pixel),
    .subchar_line  (subchar_line),
    .char_column   (char_column),
    .char_line     (char_line),
    .graph_pixel   (graph_pixel),
    .graph_line_3x (graph_line_3x),
    .mode_graph    (mode_graph),
    .css           (css),
    .rgb           (rgb)
  );

  always #5 pixel_clock = ~pixel_clock;

  logic [7:0] vram [2048];
  logic [7:0] font [1024];

  always @(posedge pixel_clock) begin
    mem_if.vram_data <= vram[mem_if.vram_addr];
    mem_if.font_data <= font[mem_if.font_addr];
  end

  typedef struct packed {
    logic       mode;
    logic       css;
    logic       blank;
    logic       border;
    logic [6:0] col;
    logic [6:0] line;
    logic [3:0] spx;
    logic [4:0] sln;
    logic [8:0] gpx;
    logic [9:0] gln;
  } pix_t;

  typedef struct {
    pix_t        p;
    logic [23:0] exp;
  } vec_t;

  typedef struct {
    bit          valid;
    bit          mode;
    bit          css;
    logic [23:0] colour;
  } exp_t;

  typedef struct {
    bit chk;
    int addr;
  } fexp_t;

  vec_t  tbl[$];
  exp_t  q[$];
  fexp_t fq[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [23:0] pal8(input int i);
    case (i)
      0: return 24'h00FF00;
      1: return 24'hFFFF00;
      2: return 24'h0000FF;
      3: return 24'hFF0000;
      4: return 24'hFFFFC0;
      5: return 24'h00FFFF;
      6: return 24'hFF00FF;
      default: return 24'hFF8000;
    endcase
  endfunction

  function automatic int vaddr(input pix_t p);
    if (p.mode) return ((int'(p.gln) / 8) % 64) * 32 + int'(p.gpx) / 16;
    return (int'(p.line) % 16) * 32 + int'(p.col) % 32;
  endfunction

  function automatic int faddr(input pix_t p);
    int a;
    a = vaddr(p);
    return (int'(vram[a[10:0]]) % 64) * 16 + int'(p.sln) / 2;
  endfunction

  function automatic logic [23:0] model_colour(input pix_t p);
    int a, code, row, bitn, pair, c, quad, fa, on;
    a = vaddr(p);
    code = int'(vram[a[10:0]]);
    if (p.mode) begin
      pair = (int'(p.gpx) / 4) % 4;
      c = (code >> (6 - 2 * pair)) % 4;
      return pal8((p.css ? 4 : 0) + c);
    end
    row  = int'(p.sln) / 2;
    bitn = 7 - int'(p.spx) / 2;
    if (code >= 128) begin
      quad = (row < 6 ? 2 : 0) + (bitn >= 4 ? 1 : 0);
      return ((code >> quad) % 2 == 1) ? pal8((code / 16) % 8) : 24'h000000;
    end
    fa = faddr(p);
    on = ((int'(font[fa[9:0]]) >> bitn) % 2) ^ ((code / 64) % 2);
    if (on == 1) return p.css ? 24'hFF8000 : 24'h00FF00;
    return 24'h003000;
  endfunction

  task automatic prefill();
    exp_t  e;
    fexp_t f;
    q.delete();
    fq.delete();
    e.valid = 0; e.mode = 0; e.css = 0; e.colour = '0;
    f.chk = 0; f.addr = 0;
    repeat (6) q.push_back(e);
    repeat (3) fq.push_back(f);
  endtask

  task automatic step(input pix_t p, output logic [23:0] got);
    exp_t        e, o;
    fexp_t       f, fo;
    logic [23:0] want;
    mode_graph = p.mode; css = p.css; blank = p.blank; show_border = p.border;
    char_column = p.col; char_line = p.line; subchar_pixel = p.spx; subchar_line = p.sln;
    graph_pixel = p.gpx; graph_line_3x = p.gln;
    e.valid = 1; e.mode = p.mode; e.css = p.css; e.colour = model_colour(p);
    q.push_back(e);
    f.chk = !p.mode; f.addr = p.mode ? 0 : faddr(p);
    fq.push_back(f);
    @(posedge pixel_clock);
    #1;
    o = q.pop_front();
    fo = fq.pop_front();
    if (p.blank || !o.valid) want = 24'h0;
    else if (p.border) want = o.mode ? (o.css ? 24'hFFFFC0 : 24'h00FF00) : 24'h0;
    else want = o.colour;
    check("rgb_model", {8'h0, rgb}, {8'h0, want});
    check("vram_addr", {21'h0, mem_if.vram_addr}, vaddr(p));
    if (fo.chk) check("font_addr", {22'h0, mem_if.font_addr}, fo.addr);
    got = rgb;
  endtask

  task automatic do_reset(input int cycles);
    reset = 1'b0;
    #1;
    check("reset_rgb", {8'h0, rgb}, 32'h0);
    check("reset_vram_addr", {21'h0, mem_if.vram_addr}, 32'h0);
    check("reset_font_addr", {22'h0, mem_if.font_addr}, 32'h0);
    repeat (cycles) @(posedge pixel_clock);
    #1;
    reset = 1'b1;
    prefill();
  endtask

  function automatic pix_t txt(input bit c, input int col, input int line, input int spx,
                               input int sln);
    pix_t p;
    p = '0;
    p.css = c; p.col = 7'(col); p.line = 7'(line); p.spx = 4'(spx); p.sln = 5'(sln);
    return p;
  endfunction

  function automatic pix_t gfx(input bit c, input int gpx, input int gln);
    pix_t p;
    p = '0;
    p.mode = 1'b1; p.css = c; p.gpx = 9'(gpx); p.gln = 10'(gln);
    return p;
  endfunction

  task automatic add(input pix_t p, input logic [23:0] e);
    vec_t v;
    v.p = p;
    v.exp = e;
    tbl.push_back(v);
  endtask

  initial begin
    pix_t        p, tp, gp;
    logic [23:0] got;
    logic [23:0] seq_exp [8];

    blank = 0; show_border = 0; mode_graph = 0; css = 0;
    subchar_pixel = 0; subchar_line = 0; char_column = 0; char_line = 0;
    graph_pixel = 0; graph_line_3x = 0;

    for (int i = 0; i < 2048; i++) vram[i] = 8'($urandom);
    for (int i = 0; i < 1024; i++) font[i] = 8'($urandom);
    vram[0]  = 8'h01;   // text char, font row 0 = 0x80
    vram[1]  = 8'hC5;   // semigraphic, colour 4, quadrants 0101
    vram[2]  = 8'h41;   // inverse of char 1
    vram[32] = 8'h1B;   // graphics byte at line_3x 8..15, pixel 0..15
    font[10'h010] = 8'h80;
    font[10'h01C] = 8'hFF;

    // Normal text, char 0x01 row 0
    for (int i = 0; i < 16; i++) add(txt(0, 0, 0, i, 0), (i < 2) ? 24'h00FF00 : 24'h003000);
    // Semigraphic quadrants and the row-6 / bit-4 boundaries
    add(txt(0, 1, 0, 0, 0), 24'h000000);
    add(txt(0, 1, 0, 8, 0), 24'hFFFFC0);
    add(txt(0, 1, 0, 7, 11), 24'h000000);
    add(txt(0, 1, 0, 8, 11), 24'hFFFFC0);
    add(txt(0, 1, 0, 0, 12), 24'h000000);
    add(txt(0, 1, 0, 15, 12), 24'hFFFFC0);
    // Graphics byte 0x1B, css=1
    for (int i = 0; i < 16; i++) begin
      case (i / 4)
        0: add(gfx(1, i, 8), 24'hFFFFC0);
        1: add(gfx(1, i, 8), 24'h00FFFF);
        2: add(gfx(1, i, 8), 24'hFF00FF);
        default: add(gfx(1, i, 8), 24'hFF8000);
      endcase
    end
    // Inverse text
    add(txt(0, 2, 0, 0, 0), 24'h003000);
    add(txt(0, 2, 0, 2, 0), 24'h00FF00);
    add(txt(0, 2, 0, 15, 0), 24'h00FF00);
    // Counter wrap: column 33 -> 1, line 16 -> 0, font row 12, line_3x bit 9
    add(txt(0, 33, 16, 8, 0), 24'hFFFFC0);
    add(txt(1, 0, 0, 0, 24), 24'hFF8000);
    add(gfx(0, 12, 520), 24'hFF0000);

    #2;
    do_reset(2);

    for (int k = 0; k < tbl.size() + 6; k++) begin
      p = (k < tbl.size()) ? tbl[k].p : txt(0, 0, 0, 4, 0);
      step(p, got);
      if (k >= 6) check($sformatf("tbl_rgb[%0d]", k - 6), {8'h0, got}, {8'h0, tbl[k - 6].exp});
    end

    // Mode switch at step 3, border in each mode, blank over border
    tp = txt(1, 0, 0, 0, 0);
    gp = gfx(0, 12, 8);
    seq_exp = '{24'hFF8000, 24'h000000, 24'hFF8000, 24'hFF0000,
                24'h000000, 24'h00FF00, 24'h000000, 24'hFF0000};
    for (int k = 0; k < 14; k++) begin
      p = (k < 3) ? tp : gp;
      p.blank  = (k == 10 || k == 12);
      p.border = (k == 7 || k == 11 || k == 12);
      step(p, got);
      if (k >= 6) check($sformatf("mode_seq[%0d]", k - 6), {8'h0, got}, {8'h0, seq_exp[k - 6]});
    end

    // Mid-stream reset with a full pipeline of graphics pixels
    do_reset(3);
    for (int k = 0; k < 10; k++) begin
      p = gp;
      p.border = (k == 2);
      step(p, got);
      check($sformatf("post_reset[%0d]", k), {8'h0, got}, (k < 6) ? 32'h0 : 32'hFF0000);
    end

    // Random stimulus against the model, with a couple of asynchronous resets
    for (int i = 0; i < 600; i++) begin
      p.mode   = 1'($urandom);
      p.css    = 1'($urandom);
      p.blank  = ($urandom_range(0, 7) == 0);
      p.border = ($urandom_range(0, 3) == 0);
      p.col    = 7'($urandom);
      p.line   = 7'($urandom);
      p.spx    = 4'($urandom);
      p.sln    = 5'($urandom);
      p.gpx    = 9'($urandom);
      p.gln    = 10'($urandom);
      step(p, got);
      if (i == 200 || i == 450) do_reset(1 + i % 3);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
